// File: rtl/pn_whitener.sv
// pn_whitener: frame-aware serial PN whitener (SHR/PHR pass-through, PSDU XOR with Fibonacci LFSR)
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   tx_data            serial input bit, qualified by tx_data_valid
//   whiten_en          PSDU whitening enable, latched on the first SHR bit
//   frame_abort        drops the current frame, returns to IDLE
//   tx_out             registered serial output, qualified by tx_out_valid
//   frame_done         one-cycle strobe alongside the last frame output bit
//   busy               high while a frame is in progress
module pn_whitener #(
    parameter int                    SHR_BITS   = 80,
    parameter int                    PHR_BITS   = 16,
    parameter int                    LEN_POS    = 5,
    parameter int                    LEN_WIDTH  = 11,
    parameter int                    LFSR_WIDTH = 9,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 9'h021,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = 9'h1FF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tx_data,
    input  logic tx_data_valid,
    input  logic whiten_en,
    input  logic frame_abort,
    output logic tx_out,
    output logic tx_out_valid,
    output logic frame_done,
    output logic busy
);
    localparam int MAXB = SHR_BITS > PHR_BITS ? SHR_BITS : PHR_BITS;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int PW   = LEN_WIDTH + 3;
    localparam logic [CW-1:0] SHR_LAST = CW'(SHR_BITS - 1);
    localparam logic [CW-1:0] PHR_LAST = CW'(PHR_BITS - 1);
    localparam logic [CW-1:0] LEN_LO   = CW'(LEN_POS);
    localparam logic [CW-1:0] LEN_HI   = CW'(LEN_POS + LEN_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHR, PHR, PSDU} state_t;

    state_t                  state;
    logic [CW-1:0]           bit_cnt;
    logic [LEN_WIDTH-1:0]    len_reg;
    logic [PW-1:0]           psdu_cnt;
    logic [LFSR_WIDTH-1:0]   lfsr;
    logic                    wen;
    logic                    in_len;
    logic [LEN_WIDTH-1:0]    len_nxt;
    logic [LFSR_WIDTH-1:0]   lfsr_nxt;

    // len_nxt includes the current bit so a length field ending on the last PHR bit is seen in time
    always_comb begin
        in_len   = bit_cnt >= LEN_LO && bit_cnt <= LEN_HI;
        len_nxt  = in_len ? {len_reg[LEN_WIDTH-2:0], tx_data} : len_reg;
        lfsr_nxt = {^(lfsr & LFSR_TAPS), lfsr[LFSR_WIDTH-1:1]};
    end

    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            len_reg      <= '0;
            psdu_cnt     <= '0;
            lfsr         <= LFSR_SEED;
            wen          <= 1'b0;
            tx_out       <= 1'b0;
            tx_out_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else if (frame_abort) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            len_reg      <= '0;
            psdu_cnt     <= '0;
            lfsr         <= LFSR_SEED;
            tx_out_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            tx_out_valid <= tx_data_valid;
            frame_done   <= 1'b0;
            if (tx_data_valid) begin
                case (state)
                    IDLE: begin
                        tx_out  <= tx_data;
                        wen     <= whiten_en;
                        lfsr    <= LFSR_SEED;
                        len_reg <= '0;
                        bit_cnt <= (SHR_BITS == 1) ? '0 : CW'(1);
                        state   <= (SHR_BITS == 1) ? PHR : SHR;
                    end
                    SHR: begin
                        tx_out  <= tx_data;
                        bit_cnt <= bit_cnt == SHR_LAST ? '0 : bit_cnt + 1'b1;
                        state   <= bit_cnt == SHR_LAST ? PHR : SHR;
                    end
                    PHR: begin
                        tx_out  <= tx_data;
                        len_reg <= len_nxt;
                        bit_cnt <= bit_cnt == PHR_LAST ? '0 : bit_cnt + 1'b1;
                        if (bit_cnt == PHR_LAST) begin
                            frame_done <= len_nxt == '0;
                            psdu_cnt   <= {len_nxt, 3'b000};
                            state      <= len_nxt == '0 ? IDLE : PSDU;
                        end
                    end
                    PSDU: begin
                        tx_out     <= tx_data ^ (wen & lfsr[0]);
                        lfsr       <= wen ? lfsr_nxt : lfsr;
                        psdu_cnt   <= psdu_cnt - 1'b1;
                        frame_done <= psdu_cnt == PW'(1);
                        state      <= psdu_cnt == PW'(1) ? IDLE : PSDU;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pn_whitener.sv
// tb_pn_whitener: directed self-checking bench for pn_whitener
module tb_pn_whitener;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tx_data = 1'b0;
    logic tx_data_valid = 1'b0;
    logic whiten_en = 1'b0;
    logic frame_abort = 1'b0;
    logic tx_out;
    logic tx_out_valid;
    logic frame_done;
    logic busy;

    int       n_cmp = 0;
    int       n_err = 0;
    bit       stall = 1'b0;
    logic     last_out = 1'b0;
    logic     cur_busy = 1'b0;
    logic [7:0] pn [4];
    logic [7:0] pd [4];

    pn_whitener dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .whiten_en(whiten_en), .frame_abort(frame_abort), .tx_out(tx_out),
        .tx_out_valid(tx_out_valid), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic d, input logic v, input logic ab);
        tx_data = d;
        tx_data_valid = v;
        frame_abort = ab;
        @(posedge clk);
        #1;
    endtask

    // one accepted bit, optionally preceded by a random invalid cycle
    task automatic sbit(input logic d, input logic e, input logic done, input string tag);
        if (stall && $urandom_range(0, 1) == 1) begin
            tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            check({tag, "_stall"}, {tx_out_valid, tx_out, frame_done, busy},
                  {1'b0, last_out, 1'b0, cur_busy});
        end
        tick(d, 1'b1, 1'b0);
        cur_busy = ~done;
        last_out = e;
        check(tag, {tx_out_valid, tx_out, frame_done, busy}, {1'b1, e, done, cur_busy});
    endtask

    // whiten_en is inverted after the first SHR bit to show it is only sampled at frame start
    task automatic frame(input bit wen, input int len, input int abort_at, input int cut_phr);
        logic [15:0] phr;
        logic d;
        logic e;
        phr = {5'b10110, 11'(len)};
        whiten_en = wen;
        for (int i = 0; i < 80; i++) begin
            d = 1'(i % 3 != 1);
            sbit(d, d, 1'b0, "shr");
            whiten_en = ~wen;
        end
        for (int i = 0; i < 16; i++) begin
            if (i == cut_phr) return;
            sbit(phr[15-i], phr[15-i], 1'(i == 15 && len == 0), "phr");
        end
        for (int k = 0; k < len * 8; k++) begin
            d = pd[k/8][k%8];
            if (k == abort_at) begin
                tick(d, 1'b1, 1'b1);
                check("abort", {tx_out_valid, 1'b0, frame_done, busy}, 4'b0000);
                cur_busy = 1'b0;
                return;
            end
            e = wen ? d ^ pn[k/8][k%8] : d;
            sbit(d, e, 1'(k == len * 8 - 1), "psdu");
        end
    endtask

    initial begin
        pn[0] = 8'hFF; pn[1] = 8'hE1; pn[2] = 8'h1D; pn[3] = 8'h9A;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("reset", {tx_out, tx_out_valid, frame_done, busy}, 4'b0000);
        reset_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        check("idle", {tx_out_valid, tx_out, frame_done, busy}, 4'b0000);

        for (int i = 0; i < 4; i++) pd[i] = 8'h00;
        frame(1'b1, 4, -1, -1);

        for (int i = 0; i < 4; i++) pd[i] = 8'hA5;
        frame(1'b0, 4, -1, -1);

        frame(1'b1, 0, -1, -1);
        for (int i = 0; i < 4; i++) pd[i] = 8'h00;
        frame(1'b1, 1, -1, -1);

        stall = 1'b1;
        frame(1'b1, 4, -1, -1);
        stall = 1'b0;
        frame(1'b1, 2, -1, -1);

        frame(1'b1, 4, 10, -1);
        frame(1'b1, 1, -1, -1);

        frame(1'b1, 4, -1, 5);
        reset_n = 1'b0;
        tick(1'b1, 1'b1, 1'b0);
        check("reset_mid", {tx_out, tx_out_valid, frame_done, busy}, 4'b0000);
        reset_n = 1'b1;
        last_out = 1'b0;
        cur_busy = 1'b0;
        frame(1'b1, 4, -1, -1);

        tick(1'b0, 1'b0, 1'b0);
        check("tail_idle", {tx_out_valid, frame_done, busy, 1'b0}, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
